// File: rtl/bpred_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encoding,
// table entry layout and counter init/allocation values.
package bpred_pkg;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

    // Widest tag across the legal ENTRIES range; narrower tags are zero-extended.
    localparam int TAG_MAX = 28;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        ctr_t               ctr;
        logic [31:0]        target;
    } entry_t;

    localparam ctr_t CTR_INIT  = WNT;
    localparam ctr_t CTR_ALLOC = WT;
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolution and statistics bus of the branch predictor.
interface bpred_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        clear;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, clear,
        input  pred_taken, pred_target, stat_branches, stat_mispred
    );
    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, clear,
        output pred_taken, pred_target, stat_branches, stat_mispred
    );
endinterface

// File: rtl/sat_ctr2.sv
// Next-state of a 2-bit saturating direction counter.
module sat_ctr2
    import bpred_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i && ctr_i != ST)
            ctr_o = ctr_t'(ctr_i + 2'd1);
        else if (!taken_i && ctr_i != SNT)
            ctr_o = ctr_t'(ctr_i - 2'd1);
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: combinational lookup on if_pc, one-cycle learning
// from execute-resolved branches, saturating branch/mispredict counters.
module branch_predictor
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input logic   clk,
    input logic   rst_n,
    bpred_if.slave bp
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [ENTRIES-1:0] valid_q, valid_d;
    ctr_t               ctr_q [ENTRIES];
    ctr_t               ctr_d [ENTRIES];
    logic [TAG_MAX-1:0] tag_q [ENTRIES];
    logic [TAG_MAX-1:0] tag_d [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [31:0]        tgt_d [ENTRIES];
    logic [31:0]        stat_branches_q, stat_branches_d;
    logic [31:0]        stat_mispred_q, stat_mispred_d;

    logic [IDX-1:0]     lk_idx, up_idx;
    logic [TAG_MAX-1:0] lk_tag, up_tag;
    entry_t             lk_e;
    logic               lk_hit, lk_taken, up_hit, mispred;
    ctr_t               up_ctr_nxt;
    logic               unused_pc_lsb;

    assign unused_pc_lsb = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

    assign lk_idx = bp.if_pc[IDX+1:2];
    assign lk_tag = TAG_MAX'(bp.if_pc[31:IDX+2]);
    assign up_idx = bp.upd_pc[IDX+1:2];
    assign up_tag = TAG_MAX'(bp.upd_pc[31:IDX+2]);

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign lk_e     = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx],
                        ctr: ctr_q[lk_idx], target: tgt_q[lk_idx]};
    assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
    assign lk_taken = lk_hit && (lk_e.ctr == WT || lk_e.ctr == ST);

    assign bp.pred_taken    = lk_taken;
    assign bp.pred_target   = lk_taken ? lk_e.target : 32'h0;
    assign bp.stat_branches = stat_branches_q;
    assign bp.stat_mispred  = stat_mispred_q;

    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign mispred = bp.upd_valid && (bp.upd_pred_taken != bp.upd_taken);

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (ctr_q[up_idx]),
        .taken_i (bp.upd_taken),
        .ctr_o   (up_ctr_nxt)
    );

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (bp.clear) begin
            valid_d = '0;
        end else if (bp.upd_valid) begin
            if (up_hit) begin
                ctr_d[up_idx] = up_ctr_nxt;
                if (bp.upd_taken) tgt_d[up_idx] = bp.upd_target;
            end else if (bp.upd_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = bp.upd_target;
                ctr_d[up_idx]   = CTR_ALLOC;
            end
        end
    end

    // Statistics still count an update that loses to clear.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (bp.upd_valid && stat_branches_q != 32'hFFFF_FFFF)
            stat_branches_d = stat_branches_q + 32'd1;
        if (mispred && stat_mispred_q != 32'hFFFF_FFFF)
            stat_mispred_d = stat_mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            ctr_q           <= ctr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    if (TAGW > TAG_MAX) begin : g_bad_entries
        $error("ENTRIES too small for entry tag width");
    end
endmodule
